elevator_scan_ctrl: RTL

Parametrised successor to the 5-floor elevator controller, serving NUM_FLOORS floors.
- Separate hall-up, hall-down and car request vectors, each latched as pending bits.
- SCAN (collective) scheduling: keeps the travel direction while requests remain ahead; stops only where a car request or a same-direction hall request exists.
- Sits between debounced button inputs and the floor/direction/door indicator drivers.

---
 rtl/elevator_pkg.sv | 20 ++
 rtl/elevator_req_latch.sv | 32 +++
 rtl/elevator_scan_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared state/direction types and request-position helpers for the elevator controller
package elevator_pkg;

  typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR, STOP} state_t;
  typedef enum logic {UP = 1'b0, DN = 1'b1} dir_t;

  // Vectors are zero-extended to 16 bits so one helper serves every floor count.
  function automatic logic any_above(input logic [15:0] vec, input logic [3:0] f);
    logic [15:0] mask;
    mask = ~((16'd2 << f) - 16'd1);
    return |(vec & mask);
  endfunction

  function automatic logic any_below(input logic [15:0] vec, input logic [3:0] f);
    logic [15:0] mask;
    mask = (16'd1 << f) - 16'd1;
    return |(vec & mask);
  endfunction

endpackage

// File: rtl/elevator_req_latch.sv
// rtl/elevator_req_latch.sv - rising-edge request capture into pending bits; a set in the same cycle as its clear wins
module elevator_req_latch #(
  parameter int            N     = 8,
  parameter logic [N-1:0]  VALID = '1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_block,
  input  logic [N-1:0] i_clr,
  output logic [N-1:0] o_rise,
  output logic [N-1:0] o_pend
);

  logic [N-1:0] r_prev;
  logic [N-1:0] r_pend;

  assign o_rise = i_req & ~r_prev & VALID;
  assign o_pend = r_pend;

  // Blocked rises are consumed by an open door at that floor instead of latching.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev <= '0;
      r_pend <= '0;
    end else begin
      r_prev <= i_req;
      r_pend <= (r_pend & ~i_clr) | (o_rise & ~i_block);
    end
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// rtl/elevator_scan_ctrl.sv - SCAN elevator controller; define ELEV_DOOR_HOLD_EN to add i_door_hold
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS       = 8,
  parameter int FLOOR_W          = $clog2(NUM_FLOORS),
  parameter int CYCLES_PER_FLOOR = 100_000_000,
  parameter int CYCLES_DOOR      = 100_000_000,
  parameter int TIMER_W          = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_FLOORS-1:0] i_req_hall_up,
  input  logic [NUM_FLOORS-1:0] i_req_hall_dn,
  input  logic [NUM_FLOORS-1:0] i_req_car,
  input  logic                  i_stop,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic                  i_door_hold,
`endif
  output logic [FLOOR_W-1:0]    o_floor,
  output logic                  o_up,
  output logic                  o_down,
  output logic                  o_door,
  output logic [NUM_FLOORS-1:0] o_pend_up,
  output logic [NUM_FLOORS-1:0] o_pend_dn,
  output logic [NUM_FLOORS-1:0] o_pend_car,
  output logic                  o_stopped
);

  if (NUM_FLOORS < 2 || NUM_FLOORS > 16 || CYCLES_PER_FLOOR < 2 || CYCLES_DOOR < 2 ||
      longint'(CYCLES_PER_FLOOR) >= (longint'(1) << TIMER_W) ||
      longint'(CYCLES_DOOR) >= (longint'(1) << TIMER_W)) begin : g_param_check
    $error("elevator_scan_ctrl: parameter out of range");
  end

  localparam logic [NUM_FLOORS-1:0] ONE       = NUM_FLOORS'(1);
  localparam logic [NUM_FLOORS-1:0] HUP_VALID = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] HDN_VALID = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
  localparam logic [TIMER_W-1:0]    FLOOR_LAST = TIMER_W'(CYCLES_PER_FLOOR - 1);
  localparam logic [TIMER_W-1:0]    DOOR_LAST  = TIMER_W'(CYCLES_DOOR - 1);
  localparam logic [FLOOR_W-1:0]    TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

  state_t r_state, r_saved, w_state_base, w_state_nx, w_saved_nx;
  dir_t   r_dir, w_dir_base, w_dir_nx, w_enter_dir, w_idle_dir;
  logic [FLOOR_W-1:0] r_floor, w_floor_nx, w_up_floor, w_dn_floor, w_enter_floor;
  logic [TIMER_W-1:0] r_timer, w_timer_nx;
  logic r_stop_prev, r_up, r_dn, r_door, r_stopped;
  logic w_stop_rise, w_hold, w_enter, w_enter_ahead, w_above, w_below, w_idle_serve;
  logic w_in_door, w_door_hit;
  logic [NUM_FLOORS-1:0] w_pend_car, w_pend_up, w_pend_dn, w_all, w_floor_bit;
  logic [NUM_FLOORS-1:0] w_rise_car, w_rise_up, w_rise_dn;
  logic [NUM_FLOORS-1:0] w_clr_car, w_clr_up, w_clr_dn, w_blk_car, w_blk_up, w_blk_dn;

`ifdef ELEV_DOOR_HOLD_EN
  assign w_hold = i_door_hold;
`else
  assign w_hold = 1'b0;
`endif

  elevator_req_latch #(.N(NUM_FLOORS), .VALID('1)) u_car (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req_car), .i_block(w_blk_car),
    .i_clr(w_clr_car), .o_rise(w_rise_car), .o_pend(w_pend_car));
  elevator_req_latch #(.N(NUM_FLOORS), .VALID(HUP_VALID)) u_hall_up (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req_hall_up), .i_block(w_blk_up),
    .i_clr(w_clr_up), .o_rise(w_rise_up), .o_pend(w_pend_up));
  elevator_req_latch #(.N(NUM_FLOORS), .VALID(HDN_VALID)) u_hall_dn (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req_hall_dn), .i_block(w_blk_dn),
    .i_clr(w_clr_dn), .o_rise(w_rise_dn), .o_pend(w_pend_dn));

  assign w_all       = w_pend_car | w_pend_up | w_pend_dn;
  assign w_above     = any_above(16'(w_all), 4'(r_floor));
  assign w_below     = any_below(16'(w_all), 4'(r_floor));
  assign w_up_floor  = (r_floor == TOP_FLOOR) ? r_floor : r_floor + FLOOR_W'(1);
  assign w_dn_floor  = (r_floor == '0) ? r_floor : r_floor - FLOOR_W'(1);
  assign w_stop_rise = i_stop & ~r_stop_prev;

  // From IDLE, a lone opposite-direction hall call with work still ahead is served by turning around.
  assign w_idle_serve = w_pend_car[r_floor] |
                        ((r_dir == UP) ? (w_pend_up[r_floor] | !w_above) : (w_pend_dn[r_floor] | !w_below));
  assign w_idle_dir   = w_idle_serve ? r_dir : ((r_dir == UP) ? DN : UP);

  assign w_floor_bit = ONE << r_floor;
  assign w_in_door   = (r_state == DOOR);
  assign w_blk_car   = w_in_door ? w_floor_bit : '0;
  assign w_blk_up    = (w_in_door && r_dir == UP) ? w_floor_bit : '0;
  assign w_blk_dn    = (w_in_door && r_dir == DN) ? w_floor_bit : '0;
  assign w_door_hit  = |((w_rise_car & w_blk_car) | (w_rise_up & w_blk_up) | (w_rise_dn & w_blk_dn));

  always_comb begin
    w_state_base  = r_state;
    w_dir_base    = r_dir;
    w_floor_nx    = r_floor;
    w_timer_nx    = r_timer;
    w_enter       = 1'b0;
    w_enter_floor = r_floor;
    w_enter_dir   = r_dir;
    case (r_state)
      IDLE: begin
        if (w_all[r_floor]) begin
          w_state_base = DOOR;
          w_timer_nx   = '0;
          w_enter      = 1'b1;
          w_enter_dir  = w_idle_dir;
        end else if (w_above && (r_dir == UP || !w_below)) begin
          w_state_base = MOVE_UP;
          w_dir_base   = UP;
          w_timer_nx   = '0;
        end else if (w_below) begin
          w_state_base = MOVE_DOWN;
          w_dir_base   = DN;
          w_timer_nx   = '0;
        end
      end
      MOVE_UP: begin
        if (r_timer == FLOOR_LAST) begin
          w_timer_nx = '0;
          w_floor_nx = w_up_floor;
          if (w_pend_car[w_up_floor] || w_pend_up[w_up_floor] ||
              !any_above(16'(w_all), 4'(w_up_floor))) begin
            w_state_base  = DOOR;
            w_enter       = 1'b1;
            w_enter_floor = w_up_floor;
            w_enter_dir   = UP;
          end
        end else begin
          w_timer_nx = r_timer + TIMER_W'(1);
        end
      end
      MOVE_DOWN: begin
        if (r_timer == FLOOR_LAST) begin
          w_timer_nx = '0;
          w_floor_nx = w_dn_floor;
          if (w_pend_car[w_dn_floor] || w_pend_dn[w_dn_floor] ||
              !any_below(16'(w_all), 4'(w_dn_floor))) begin
            w_state_base  = DOOR;
            w_enter       = 1'b1;
            w_enter_floor = w_dn_floor;
            w_enter_dir   = DN;
          end
        end else begin
          w_timer_nx = r_timer + TIMER_W'(1);
        end
      end
      DOOR: begin
        if (w_door_hit || w_hold) begin
          w_timer_nx = '0;
        end else if (r_timer == DOOR_LAST) begin
          w_state_base = IDLE;
          w_timer_nx   = '0;
        end else begin
          w_timer_nx = r_timer + TIMER_W'(1);
        end
      end
      STOP: begin
      end
      default: w_state_base = IDLE;
    endcase

    // The stop toggle edge still performs this cycle's step; the result is parked in r_saved.
    w_saved_nx = r_saved;
    if (r_state == STOP) begin
      w_state_nx = w_stop_rise ? r_saved : STOP;
    end else if (w_stop_rise) begin
      w_state_nx = STOP;
      w_saved_nx = w_state_base;
    end else begin
      w_state_nx = w_state_base;
    end
  end

  assign w_enter_ahead = (w_enter_dir == UP) ? any_above(16'(w_all), 4'(w_enter_floor))
                                             : any_below(16'(w_all), 4'(w_enter_floor));

  always_comb begin
    w_clr_car = '0;
    w_clr_up  = '0;
    w_clr_dn  = '0;
    w_dir_nx  = w_dir_base;
    if (w_enter) begin
      w_clr_car = ONE << w_enter_floor;
      if (w_enter_dir == UP || !w_enter_ahead) w_clr_up = ONE << w_enter_floor;
      if (w_enter_dir == DN || !w_enter_ahead) w_clr_dn = ONE << w_enter_floor;
      w_dir_nx = w_enter_ahead ? w_enter_dir : ((w_enter_dir == UP) ? DN : UP);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_saved     <= IDLE;
      r_dir       <= UP;
      r_floor     <= '0;
      r_timer     <= '0;
      r_stop_prev <= 1'b0;
      r_up        <= 1'b0;
      r_dn        <= 1'b0;
      r_door      <= 1'b0;
      r_stopped   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_saved     <= w_saved_nx;
      r_dir       <= w_dir_nx;
      r_floor     <= w_floor_nx;
      r_timer     <= w_timer_nx;
      r_stop_prev <= i_stop;
      r_up        <= (w_state_nx == MOVE_UP);
      r_dn        <= (w_state_nx == MOVE_DOWN);
      r_door      <= (w_state_nx == DOOR);
      r_stopped   <= (w_state_nx == STOP);
    end
  end

  assign o_floor    = r_floor;
  assign o_up       = r_up;
  assign o_down     = r_dn;
  assign o_door     = r_door;
  assign o_stopped  = r_stopped;
  assign o_pend_car = w_pend_car;
  assign o_pend_up  = w_pend_up;
  assign o_pend_dn  = w_pend_dn;

endmodule
